counter_scoreboard: RTL and testbench
=====================================

COUNTER_SCOREBOARD -- requirements
Module: counter_scoreboard

Interface
REQ-001 Parameter N, default 3: counter width under check.
REQ-002 Parameter ERR_W, default 8: width of the error and check counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 syn_clr, load, en, up  input  1 each  counter control stimulus, sampled same edge as the DUT.
REQ-006 d  input  N  counter load data.
REQ-007 q  input  N  DUT count under check.
REQ-008 max_tick, min_tick  input  1 each  DUT flags under check.
REQ-009 start  input  1  single-cycle pulse; arms checking.
REQ-010 stop  input  1  single-cycle pulse; ends checking.
REQ-011 err_pulse  output  1  registered; high one cycle per mismatching checked cycle.
REQ-012 err_cnt  output  ERR_W  number of mismatching checked cycles, saturating.
REQ-013 chk_cnt  output  ERR_W  number of checked cycles, saturating.
REQ-014 first_q, first_exp  output  N each  DUT q and expected q from the first mismatch.
REQ-015 pass, fail  output  1 each  verdict flags.
REQ-016 busy  output  1  high while in CHECK.

Function
REQ-017 Golden model SHALL hold exp (N bits), updated per edge with priority syn_clr (exp=0) > load (exp=d) > en&up (exp+1, mod 2^N) > en&~up (exp-1, mod 2^N) > hold.
REQ-018 Model SHALL track stimulus in every FSM state, so the model stays in lockstep with the DUT before start.
REQ-019 Expected flags: exp_max = (exp == 2^N-1), exp_min = (exp == 0), both combinational from exp.
REQ-020 A cycle mismatches when in CHECK and any of q!=exp, max_tick!=exp_max, min_tick!=exp_min.
REQ-021 err_pulse SHALL assert the edge after a mismatching cycle; latency 1 clock.
REQ-022 FSM states IDLE, CHECK, DONE; IDLE -start-> CHECK; CHECK -stop-> DONE; DONE -start-> CHECK.
REQ-023 stop in IDLE and start in CHECK SHALL be ignored; start and stop in the same cycle: start takes effect only from IDLE/DONE, stop only from CHECK.
REQ-024 Entering CHECK SHALL clear err_cnt, chk_cnt, first_q, first_exp on the transition edge.
REQ-025 chk_cnt increments once per cycle in CHECK; err_cnt once per mismatching cycle; both saturate at 2^ERR_W-1, no wrap.
REQ-026 first_q/first_exp SHALL load only on the first mismatch after entering CHECK (err_cnt==0), then hold.
REQ-027 fail = (err_cnt != 0), any state; pass = DONE and err_cnt==0 and chk_cnt!=0.
REQ-028 Wrap cases: exp 7 with up -> 0; exp 0 with down -> 7 (N=3); checked like any other cycle.

Reset
REQ-029 rst_n low SHALL immediately force: FSM IDLE, exp 0, err_pulse 0, err_cnt 0, chk_cnt 0, first_q 0, first_exp 0, pass 0, fail 0, busy 0.
REQ-030 Reset mid-CHECK SHALL abandon the run; no verdict retained.

Structure
REQ-031 FSM state encodings and a default-width constant SHALL live in a shared counter_scoreboard_pkg header.
REQ-032 Golden model SHALL be one sub-module, universal_binary_counter instantiated with the same N, driven by the same stimulus.

Verification
REQ-033 Reset, start, en=1 up=1 for 10 cycles, stop, matching DUT -> err_cnt=0, chk_cnt=10, pass=1.
REQ-034 Inject q=5 where exp=4 on 3rd checked cycle -> err_pulse one cycle later, err_cnt=1, first_q=5, first_exp=4, fail=1.
REQ-035 N=3, exp=7, up count with max_tick forced 0 -> mismatch counted; next cycle exp=0, min_tick=1 matches.
REQ-036 syn_clr and load (d=6) same cycle -> exp=0; load only d=6 -> exp=6.
REQ-037 Force mismatch every cycle for 300 cycles, ERR_W=8 -> err_cnt holds 255.
REQ-038 rst_n low mid-CHECK with err_cnt=2 -> all outputs 0 asynchronously, FSM IDLE, stop ignored after.

Source files
------------

// File: rtl/counter_scoreboard_pkg.sv
// ============================================================================
// counter_scoreboard_pkg : shared state encodings, default widths, stimulus type
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_scoreboard_pkg;

  localparam int DEFAULT_N     = 3;
  localparam int DEFAULT_ERR_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic syn_clr;
    logic load;
    logic en;
    logic up;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/universal_binary_counter.sv
// ============================================================================
// universal_binary_counter : up/down counter with sync clear and load
// Rev 1.0
// ============================================================================
`default_nettype none

module universal_binary_counter
  import counter_scoreboard_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  ctrl_t        i_ctrl,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q,
  output logic         o_max_tick,
  output logic         o_min_tick
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_ctrl.syn_clr) begin
      r_q <= '0;
    end else if (i_ctrl.load) begin
      r_q <= i_d;
    end else if (i_ctrl.en) begin
      r_q <= i_ctrl.up ? r_q + 1'b1 : r_q - 1'b1;
    end
  end

  assign o_q        = r_q;
  assign o_max_tick = &r_q;
  assign o_min_tick = ~|r_q;

endmodule

`default_nettype wire

// File: rtl/counter_scoreboard.sv
// ============================================================================
// counter_scoreboard : checks a counter DUT against a lockstep golden counter
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_scoreboard
  import counter_scoreboard_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int ERR_W = DEFAULT_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             syn_clr,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [N-1:0]     d,
  input  logic [N-1:0]     q,
  input  logic             max_tick,
  input  logic             min_tick,
  input  logic             start,
  input  logic             stop,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] chk_cnt,
  output logic [N-1:0]     first_q,
  output logic [N-1:0]     first_exp,
  output logic             pass,
  output logic             fail,
  output logic             busy
);

  logic [1:0]       r_state;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] r_chk_cnt;
  logic [N-1:0]     r_first_q;
  logic [N-1:0]     r_first_exp;

  ctrl_t            w_ctrl;
  logic [N-1:0]     w_exp;
  logic             w_exp_max;
  logic             w_exp_min;
  logic             w_in_check;
  logic             w_enter_check;
  logic             w_mismatch;

  // Golden model runs in every state so it is already aligned when checking starts.
  assign w_ctrl = {syn_clr, load, en, up};

  universal_binary_counter #(
    .N (N)
  ) u_golden (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ctrl     (w_ctrl),
    .i_d        (d),
    .o_q        (w_exp),
    .o_max_tick (w_exp_max),
    .o_min_tick (w_exp_min)
  );

  assign w_in_check    = (r_state == ST_CHECK);
  assign w_enter_check = start && !w_in_check;
  assign w_mismatch    = w_in_check &&
                         ((q != w_exp) || (max_tick != w_exp_max) || (min_tick != w_exp_min));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (w_enter_check) begin
      r_state <= ST_CHECK;
    end else if (w_in_check && stop) begin
      r_state <= ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_chk_cnt   <= '0;
      r_first_q   <= '0;
      r_first_exp <= '0;
    end else begin
      r_err_pulse <= w_mismatch;
      if (w_enter_check) begin
        r_err_cnt   <= '0;
        r_chk_cnt   <= '0;
        r_first_q   <= '0;
        r_first_exp <= '0;
      end else if (w_in_check) begin
        if (r_chk_cnt != '1) begin
          r_chk_cnt <= r_chk_cnt + 1'b1;
        end
        if (w_mismatch) begin
          if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 1'b1;
          end
          // Capture only the first mismatch of the run.
          if (r_err_cnt == '0) begin
            r_first_q   <= q;
            r_first_exp <= w_exp;
          end
        end
      end
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign chk_cnt   = r_chk_cnt;
  assign first_q   = r_first_q;
  assign first_exp = r_first_exp;
  assign fail      = (r_err_cnt != '0);
  assign pass      = (r_state == ST_DONE) && (r_err_cnt == '0) && (r_chk_cnt != '0);
  assign busy      = w_in_check;

endmodule

`default_nettype wire

// File: tb/tb_counter_scoreboard.sv
// ============================================================================
// tb_counter_scoreboard : directed stimulus with a behavioural reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_scoreboard;

  localparam int N     = 3;
  localparam int ERR_W = 8;
  localparam int MOD   = 1 << N;
  localparam int SAT   = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic syn_clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
  logic start = 1'b0, stop = 1'b0;
  logic max_tick = 1'b0, min_tick = 1'b1;
  logic [N-1:0] d = '0, q = '0;

  logic             err_pulse, pass, fail, busy;
  logic [ERR_W-1:0] err_cnt, chk_cnt;
  logic [N-1:0]     first_q, first_exp;

  int checks = 0;
  int errors = 0;

  // Reference state: 0 idle, 1 checking, 2 done
  int m_exp = 0, m_state = 0, m_err = 0, m_chk = 0, m_fq = 0, m_fe = 0;
  bit m_pulse = 1'b0;

  counter_scoreboard #(.N(N), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q), .max_tick(max_tick), .min_tick(min_tick), .start(start), .stop(stop),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .chk_cnt(chk_cnt), .first_q(first_q),
    .first_exp(first_exp), .pass(pass), .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_exp = 0; m_state = 0; m_err = 0; m_chk = 0; m_fq = 0; m_fe = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    bit mism;
    mism = (m_state == 1) && ((int'(q) != m_exp) || (max_tick != (m_exp == MOD - 1)) ||
                              (min_tick != (m_exp == 0)));
    if (m_state == 1) begin
      m_chk = (m_chk < SAT) ? m_chk + 1 : SAT;
      if (mism) begin
        if (m_err == 0) begin
          m_fq = int'(q);
          m_fe = m_exp;
        end
        m_err = (m_err < SAT) ? m_err + 1 : SAT;
      end
    end
    m_pulse = mism;
    if (start && m_state != 1) begin
      m_state = 1; m_err = 0; m_chk = 0; m_fq = 0; m_fe = 0;
    end else if (stop && m_state == 1) begin
      m_state = 2;
    end
    if (syn_clr)     m_exp = 0;
    else if (load)   m_exp = int'(d);
    else if (en)     m_exp = (m_exp + (up ? 1 : MOD - 1)) % MOD;
  endtask

  always @(posedge clk) if (rst_n) model_step();

  always @(negedge clk) begin
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_cnt",   32'(err_cnt),   32'(m_err));
    chk("chk_cnt",   32'(chk_cnt),   32'(m_chk));
    chk("first_q",   32'(first_q),   32'(m_fq));
    chk("first_exp", 32'(first_exp), 32'(m_fe));
    chk("fail",      32'(fail),      32'(m_err != 0));
    chk("pass",      32'(pass),      32'(m_state == 2 && m_err == 0 && m_chk != 0));
    chk("busy",      32'(busy),      32'(m_state == 1));
  end

  // Drive one cycle; q follows the reference count plus an optional corruption.
  task automatic step(input logic sc, input logic ld, input logic e, input logic u,
                      input int dd, input logic st, input logic sp,
                      input int qerr = 0, input bit no_max = 1'b0);
    int qv;
    logic [31:0] qb;
    logic [31:0] db;
    qv = (m_exp + qerr) % MOD;
    qb = 32'(qv);
    db = 32'(dd);
    syn_clr = sc; load = ld; en = e; up = u; start = st; stop = sp;
    d = db[N-1:0];
    q = qb[N-1:0];
    max_tick = (qv == MOD - 1) && !no_max;
    min_tick = (qv == 0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   0);
    chk({tag, "_chk_cnt"},   32'(chk_cnt),   0);
    chk({tag, "_first_q"},   32'(first_q),   0);
    chk({tag, "_first_exp"}, 32'(first_exp), 0);
    chk({tag, "_pass"},      32'(pass),      0);
    chk({tag, "_fail"},      32'(fail),      0);
    chk({tag, "_busy"},      32'(busy),      0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);                 // stop while idle
    chk("idle_stop_busy", 32'(busy), 0);

    // Clean run of 10 checked up-counts, wrapping 7 -> 0
    step(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 1);
    chk("run1_err_cnt", 32'(err_cnt), 0);
    chk("run1_chk_cnt", 32'(chk_cnt), 10);
    chk("run1_pass",    32'(pass),    1);
    chk("run1_busy",    32'(busy),    0);

    // q=5 where exp=4 on the third checked cycle; start mid-run ignored
    step(0, 1, 0, 0, 2, 1, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1, 0);
    chk("inj_pulse_before", 32'(err_pulse), 0);
    step(0, 0, 1, 1, 0, 0, 0, 1);
    chk("inj_err_pulse", 32'(err_pulse), 1);
    chk("inj_err_cnt",   32'(err_cnt),   1);
    chk("inj_first_q",   32'(first_q),   5);
    chk("inj_first_exp", 32'(first_exp), 4);
    chk("inj_fail",      32'(fail),      1);
    step(0, 0, 1, 1, 0, 0, 1);
    chk("inj_pulse_after", 32'(err_pulse), 0);
    chk("inj_pass",        32'(pass),      0);

    // exp=7 with max_tick forced low, then wrap to 0 and down-wrap to 7
    step(0, 1, 0, 0, 6, 1, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0, 1'b1);
    chk("max_err_cnt",   32'(err_cnt),   1);
    chk("max_first_exp", 32'(first_exp), 7);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("wrap_pulse",   32'(err_pulse), 0);
    chk("wrap_err_cnt", 32'(err_cnt),   1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("down_wrap_err_cnt", 32'(err_cnt), 1);

    // syn_clr beats load; then load alone
    step(1, 1, 0, 0, 6, 1, 0);
    step(0, 1, 0, 0, 6, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("prio_err_cnt", 32'(err_cnt), 0);
    chk("prio_pass",    32'(pass),    1);

    // Saturation: mismatch every cycle for 300 cycles
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("sat_err_cnt", 32'(err_cnt), SAT);
    chk("sat_chk_cnt", 32'(chk_cnt), SAT);
    chk("sat_fail",    32'(fail),    1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a failing run
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 0, 0, 3);
    step(0, 0, 1, 1, 0, 0, 0);
    chk("pre_rst_err_cnt", 32'(err_cnt), 2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_pass", 32'(pass), 0);
    step(0, 0, 1, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
